// File: rtl/data_axi_bridge.sv
// data_axi_bridge
// Data-side bridge from the MEM stage's SRAM-style request to a single-beat
// AXI master port. One transaction outstanding at a time; the pipeline is
// held with `stall` until the access completes.
// Optional feature macro: DBRIDGE_WRITE_BUFFER_EN adds a one-entry posted
// write buffer that drains on its own AW/W/B sequence.
module data_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   // MEM-stage request
   input  logic        req_rd_en,
   input  logic        req_wr_en,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wsel,
   input  logic [31:0] req_wdata,
   output logic [31:0] req_rdata,
   output logic        stall,
   // AR channel
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   // R channel
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   // AW channel
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   // W channel
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // B channel
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_RESP = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_arvalid;
   logic        r_rready;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;
   logic        r_aw_done;
   logic        r_w_done;
   logic [31:0] r_araddr;
   logic [31:0] r_awaddr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_rdata;

   logic        w_ar_hs;
   logic        w_r_hs;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_b_hs;
   logic        w_rd_start;
   logic        w_wr_start;
   logic        w_wreq_cur;
   logic        w_both_done;
   logic        w_aw_done_nxt;
   logic        w_w_done_nxt;
   logic        w_wreq_nxt;
   logic        w_wresp_nxt;
   logic        w_busy;
   logic        w_stall;

   // Response codes and rlast carry no information for a single-beat,
   // error-ignoring bridge.
   logic        w_unused;
   assign w_unused = ^{rresp, bresp, rlast};

`ifdef DBRIDGE_WRITE_BUFFER_EN
   logic        r_wb_valid;
   logic        r_wb_resp;
`endif

   assign w_ar_hs = r_arvalid & arready;
   assign w_r_hs  = r_rready  & rvalid;
   assign w_aw_hs = r_awvalid & awready;
   assign w_w_hs  = r_wvalid  & wready;
   assign w_b_hs  = r_bready  & bvalid;

   // Main FSM next-state decode; the request is accepted only from IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_rd_start  = 1'b0;
      w_wr_start  = 1'b0;
      case (r_state)
         S_IDLE: begin
`ifdef DBRIDGE_WRITE_BUFFER_EN
            // Stores go to the posted buffer; the main FSM only runs loads,
            // and a load waits until any buffered write has seen its B.
            if (req_wr_en) begin
               w_wr_start  = ~r_wb_valid;
               w_state_nxt = S_IDLE;
            end else if (req_rd_en && !r_wb_valid) begin
               w_rd_start  = 1'b1;
               w_state_nxt = S_RD_ADDR;
            end else begin
               w_state_nxt = S_IDLE;
            end
`else
            // Store wins over a simultaneous load.
            if (req_wr_en) begin
               w_wr_start  = 1'b1;
               w_state_nxt = S_WR_REQ;
            end else if (req_rd_en) begin
               w_rd_start  = 1'b1;
               w_state_nxt = S_RD_ADDR;
            end else begin
               w_state_nxt = S_IDLE;
            end
`endif
         end
         S_RD_ADDR: begin
            if (w_ar_hs) begin
               w_state_nxt = S_RD_DATA;
            end else begin
               w_state_nxt = S_RD_ADDR;
            end
         end
         S_RD_DATA: begin
            if (w_r_hs) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RD_DATA;
            end
         end
         S_WR_REQ: begin
            if (w_both_done) begin
               w_state_nxt = S_WR_RESP;
            end else begin
               w_state_nxt = S_WR_REQ;
            end
         end
         S_WR_RESP: begin
            if (w_b_hs) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_WR_RESP;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Write-side phase tracking. AW and W retire independently; the write
   // request phase ends only when both have handshaken (in any order).
`ifdef DBRIDGE_WRITE_BUFFER_EN
   assign w_wreq_cur  = r_wb_valid & ~r_wb_resp;
`else
   assign w_wreq_cur  = (r_state == S_WR_REQ);
`endif
   assign w_both_done   = w_wreq_cur & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
   assign w_aw_done_nxt = (r_aw_done | w_aw_hs) & ~w_both_done;
   assign w_w_done_nxt  = (r_w_done  | w_w_hs)  & ~w_both_done;
`ifdef DBRIDGE_WRITE_BUFFER_EN
   assign w_wreq_nxt  = w_wr_start | (w_wreq_cur & ~w_both_done);
   assign w_wresp_nxt = w_both_done | (r_wb_resp & ~w_b_hs);
`else
   assign w_wreq_nxt  = (w_state_nxt == S_WR_REQ);
   assign w_wresp_nxt = (w_state_nxt == S_WR_RESP);
`endif

   // Stall: a pending request in IDLE that cannot retire this cycle, or any
   // in-flight access. DONE releases the pipeline for exactly one cycle.
   assign w_busy = (r_state != S_IDLE) & (r_state != S_DONE);
`ifdef DBRIDGE_WRITE_BUFFER_EN
   assign w_stall = ((r_state == S_IDLE) &
                     ((req_wr_en & r_wb_valid) | (~req_wr_en & req_rd_en))) | w_busy;
`else
   assign w_stall = ((r_state == S_IDLE) & (req_rd_en | req_wr_en)) | w_busy;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered AXI valid/ready outputs and write handshake bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_arvalid <= (w_state_nxt == S_RD_ADDR);
         r_rready  <= (w_state_nxt == S_RD_DATA);
         r_awvalid <= w_wreq_nxt & ~w_aw_done_nxt;
         r_wvalid  <= w_wreq_nxt & ~w_w_done_nxt;
         r_bready  <= w_wresp_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
      end
   end

   // Latch address/data/strobes when a transaction (or buffer load) starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_araddr <= 32'd0;
         r_awaddr <= 32'd0;
         r_wdata  <= 32'd0;
         r_wstrb  <= 4'd0;
      end else begin
         if (w_rd_start) begin
            r_araddr <= req_addr;
         end else begin
            r_araddr <= r_araddr;
         end
         if (w_wr_start) begin
            r_awaddr <= req_addr;
            r_wdata  <= req_wdata;
            r_wstrb  <= req_wsel;
         end else begin
            r_awaddr <= r_awaddr;
            r_wdata  <= r_wdata;
            r_wstrb  <= r_wstrb;
         end
      end
   end

   // Load data register; holds until the next R capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= 32'd0;
      end else if (w_r_hs) begin
         r_rdata <= rdata;
      end else begin
         r_rdata <= r_rdata;
      end
   end

`ifdef DBRIDGE_WRITE_BUFFER_EN
   // Posted write buffer occupancy: request phase, then response phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_resp  <= 1'b0;
      end else if (w_wr_start) begin
         r_wb_valid <= 1'b1;
         r_wb_resp  <= 1'b0;
      end else if (w_both_done) begin
         r_wb_valid <= 1'b1;
         r_wb_resp  <= 1'b1;
      end else if (r_wb_resp && w_b_hs) begin
         r_wb_valid <= 1'b0;
         r_wb_resp  <= 1'b0;
      end else begin
         r_wb_valid <= r_wb_valid;
         r_wb_resp  <= r_wb_resp;
      end
   end
`endif

   assign req_rdata = r_rdata;
   assign stall     = w_stall;

   assign arid    = AXI_ID;
   assign araddr  = r_araddr;
   assign arlen   = 8'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign arvalid = r_arvalid;
   assign rready  = r_rready;

   assign awid    = AXI_ID;
   assign awaddr  = r_awaddr;
   assign awlen   = 8'd0;
   assign awsize  = 3'b010;
   assign awburst = 2'b01;
   assign awvalid = r_awvalid;

   assign wdata   = r_wdata;
   assign wstrb   = r_wstrb;
   assign wlast   = 1'b1;
   assign wvalid  = r_wvalid;
   assign bready  = r_bready;

endmodule

// File: tb/tb_data_axi_bridge.sv
// tb_data_axi_bridge
// Randomized bench: the bench plays MEM stage and AXI slave with chosen
// per-channel wait counts; a transaction-level model predicts the stall
// window length, load data and handshake counts from the timing rules.
// With DBRIDGE_WRITE_BUFFER_EN defined, the posted-write ordering test
// replaces the blocking-store tests.
module tb_data_axi_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_rd_en, req_wr_en;
   logic [31:0] req_addr, req_wdata, req_rdata;
   logic [3:0]  req_wsel;
   logic        stall;
   logic [3:0]  arid, awid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [3:0]  wstrb;

   data_axi_bridge dut (
      .clk(clk), .rst(rst),
      .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_addr(req_addr),
      .req_wsel(req_wsel), .req_wdata(req_wdata), .req_rdata(req_rdata), .stall(stall),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Slave plan: cycles each ready/valid is withheld after the DUT offers.
   int ar_wait, r_wait, aw_wait, w_wait, b_wait;
   int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   int ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic [31:0] slv_rdata;
   logic [31:0] last_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic slave_reset();
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
   endtask

   // Drive slave responses for the current cycle (DUT valids are registered).
   task automatic slave_drive();
      logic [31:0] junk;
      junk    = $urandom();
      arready = arvalid && (ar_cnt >= ar_wait);
      rvalid  = rready && (r_cnt >= r_wait);
      rdata   = rvalid ? slv_rdata : junk;
      rresp   = 2'($urandom_range(0, 3));
      rlast   = 1'b1;
      awready = awvalid && (aw_cnt >= aw_wait);
      wready  = wvalid && (w_cnt >= w_wait);
      bvalid  = bready && (b_cnt >= b_wait);
      bresp   = 2'($urandom_range(0, 3));
   endtask

   // Record handshakes seen in this cycle.
   task automatic slave_update();
      if (arvalid) begin if (arready) begin ar_hs++; ar_cnt = 0; end else ar_cnt++; end
      if (rready)  begin if (rvalid)  begin r_hs++;  r_cnt = 0;  end else r_cnt++;  end
      if (awvalid) begin if (awready) begin aw_hs++; aw_cnt = 0; end else aw_cnt++; end
      if (wvalid)  begin if (wready)  begin w_hs++;  w_cnt = 0;  end else w_cnt++;  end
      if (bready)  begin if (bvalid)  begin b_hs++;  b_cnt = 0;  end else b_cnt++;  end
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      req_rd_en = 1'b0; req_wr_en = 1'b0;
      slave_drive();
      @(negedge clk);
      chk("idle_stall", stall, 1'b0);
      chk("idle_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'd0);
      chk("idle_rdata_hold", req_rdata, last_rdata);
      slave_update();
   endtask

   // One blocking transaction. Model: load lasts ar_wait+r_wait+4 cycles,
   // store lasts max(aw_wait,w_wait)+b_wait+4; stall is high in all but the
   // last cycle, where a load's data is presented.
   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input logic [31:0] rd_word, input int arw, input int rw,
                          input int aww, input int ww, input int bw,
                          output int stall_cycles);
      bit store;
      int n;
      store = wr;
      ar_wait = arw; r_wait = rw; aw_wait = aww; w_wait = ww; b_wait = bw;
      slv_rdata = rd_word;
      slave_reset();
      n = store ? (((aww > ww) ? aww : ww) + bw + 4) : (arw + rw + 4);
      stall_cycles = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            req_rd_en = rd; req_wr_en = wr; req_addr = addr;
            req_wsel = sel; req_wdata = wd;
         end
         slave_drive();
         @(negedge clk);
         chk("stall", stall, (k < n - 1) ? 1'b1 : 1'b0);
         chk("req_rdata", req_rdata, (!store && k == n - 1) ? rd_word : last_rdata);
         if (store) begin
            chk("st_no_ar", arvalid, 1'b0);
            if (awvalid) chk("awaddr", awaddr, addr);
            if (wvalid) begin
               chk("wdata", wdata, wd);
               chk("wstrb", wstrb, sel);
               chk("wlast", wlast, 1'b1);
            end
            if (bready) chk("bready_after_aw_w", (aw_hs > 0 && w_hs > 0), 1'b1);
         end else begin
            chk("ld_no_wr", {awvalid, wvalid, bready}, 3'd0);
            if (arvalid) chk("araddr", araddr, addr);
         end
         if (stall) stall_cycles++;
         slave_update();
      end
      if (store) begin
         chk("aw_hs_count", aw_hs, 1); chk("w_hs_count", w_hs, 1);
         chk("b_hs_count", b_hs, 1);   chk("ar_hs_count_st", ar_hs, 0);
      end else begin
         chk("ar_hs_count", ar_hs, 1); chk("r_hs_count", r_hs, 1);
         chk("aw_hs_count_ld", aw_hs, 0);
         last_rdata = rd_word;
      end
   endtask

   initial begin
      int sc;
      logic [31:0] a, d, r;
      rst = 1'b1;
      req_rd_en = 1'b0; req_wr_en = 1'b0; req_addr = 32'd0;
      req_wsel = 4'd0; req_wdata = 32'd0;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      slv_rdata = 32'd0; last_rdata = 32'd0;
      slave_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Reset state
      chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'd0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_rdata", req_rdata, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_awaddr", awaddr, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_wstrb", wstrb, 4'd0);
      chk("ar_attrs", {arid, arlen, arsize, arburst}, {4'd1, 8'd0, 3'b010, 2'b01});
      chk("aw_attrs", {awid, awlen, awsize, awburst}, {4'd1, 8'd0, 3'b010, 2'b01});
      rst = 1'b0;

      // Zero-wait load: three stall cycles, then data.
      run_txn(1'b1, 1'b0, 32'h0000_1000, 4'd0, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, sc);
      chk("load_stall_cycles", sc, 3);
      chk("load_data_literal", req_rdata, 32'hDEAD_BEEF);
      chk("load_araddr_literal", araddr, 32'h0000_1000);
      idle_cycle();

`ifndef DBRIDGE_WRITE_BUFFER_EN
      // Store with W accepted two cycles after AW.
      run_txn(1'b0, 1'b1, 32'h0000_2004, 4'b0100, 32'h5555_5555, 32'd0, 0, 0, 0, 2, 0, sc);
      chk("store_stall_cycles", sc, 5);
      chk("store_wstrb_literal", wstrb, 4'b0100);
      // Load and store together: store wins.
      run_txn(1'b1, 1'b1, 32'h0000_3000, 4'b1111, 32'h1234_5678, 32'd0, 0, 0, 1, 0, 1, sc);
      chk("both_stall_cycles", sc, 5);
`else
      // Posted store then immediate load while B is delayed five cycles.
      begin
         bit done;
         bit stall_seen;
         ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 5;
         slv_rdata = 32'hCAFE_F00D;
         slave_reset();
         @(posedge clk); #1;
         req_wr_en = 1'b1; req_rd_en = 1'b0; req_addr = 32'h0000_3008;
         req_wsel = 4'b1111; req_wdata = 32'hA5A5_5A5A;
         slave_drive();
         @(negedge clk);
         chk("wb_store_stall", stall, 1'b0);
         slave_update();
         done = 1'b0;
         stall_seen = 1'b0;
         for (int k = 1; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
               req_wr_en = 1'b0; req_rd_en = 1'b1; req_addr = 32'h0000_4000;
            end
            slave_drive();
            @(negedge clk);
            if (arvalid) chk("wb_ar_after_b", b_hs, 1);
            if (awvalid) chk("wb_awaddr", awaddr, 32'h0000_3008);
            if (wvalid) chk("wb_wdata", wdata, 32'hA5A5_5A5A);
            if (stall) stall_seen = 1'b1;
            if (!stall) done = 1'b1;
            slave_update();
         end
         chk("wb_load_done", done, 1'b1);
         chk("wb_load_stalled", stall_seen, 1'b1);
         chk("wb_load_data", req_rdata, 32'hCAFE_F00D);
         chk("wb_b_count", b_hs, 1);
         last_rdata = 32'hCAFE_F00D;
         idle_cycle();
      end
`endif

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         int kind;
         a = $urandom(); a = a & 32'hFFFF_FFFC;
         d = $urandom(); r = $urandom();
`ifdef DBRIDGE_WRITE_BUFFER_EN
         kind = $urandom_range(0, 1);
`else
         kind = $urandom_range(0, 3);
`endif
         case (kind)
            0: idle_cycle();
            1: run_txn(1'b1, 1'b0, a, 4'd0, d, r, $urandom_range(0, 3), $urandom_range(0, 3),
                       0, 0, 0, sc);
            2: run_txn(1'b0, 1'b1, a, 4'($urandom_range(0, 15)), d, r, 0, 0,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), sc);
            default: run_txn(1'b1, 1'b1, a, 4'($urandom_range(0, 15)), d, r, 0, 0,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), sc);
         endcase
      end

      // Reset while in RD_DATA abandons the load.
      ar_wait = 0; r_wait = 10; slv_rdata = 32'h0BAD_0BAD;
      slave_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            req_rd_en = 1'b1; req_wr_en = 1'b0; req_addr = 32'h0000_5000;
         end
         slave_drive();
         @(negedge clk);
         slave_update();
      end
      chk("rd_data_rready", rready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; req_rd_en = 1'b0;
      slave_drive();
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      slave_drive();
      @(negedge clk);
      chk("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'd0);
      chk("rst_mid_stall", stall, 1'b0);
      chk("rst_mid_rdata", req_rdata, 32'd0);
      last_rdata = 32'd0;
      slave_reset();
      idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
